fifo_arb_amisha: RTL and testbench

- Two-producer write arbiter and single-consumer read sequencer wrapped around one shared fifo_Amisha instance (8-bit FIFO with wr/rd strobes and full/empty flags).
- Producers use valid/ready handshakes. The arbiter grants the FIFO write port with round-robin fairness and a bounded burst length.
- The read side exposes the FIFO head as a valid/ready stream.
- Per-producer accepted-word counters support system debug.

---
 rtl/fifo_arb_pkg_amisha.sv | 26 ++
 rtl/fifo_arb_amisha_fsm.sv | 81 ++++++++
 rtl/fifo_arb_amisha.sv | 72 +++++++
 tb/tb_fifo_arb_amisha.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg_amisha.sv
// Shared types and constants for the two-producer FIFO write arbiter.
package fifo_arb_pkg_amisha;

  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_BURST_LEN = 4;
  localparam int unsigned DEF_CNT_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_0    = 2'b01;
  localparam logic [1:0] GRANT_1    = 2'b10;

  function automatic logic [1:0] grant_of(input arb_state_e s);
    case (s)
      ST_G0:   grant_of = GRANT_0;
      ST_G1:   grant_of = GRANT_1;
      default: grant_of = GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/fifo_arb_amisha_fsm.sv
// Round-robin grant FSM with bounded bursts; grant comes only from the state register.
module rr_burst_fsm_amisha
  import fifo_arb_pkg_amisha::*;
#(
  parameter int unsigned BURST_LEN = DEF_BURST_LEN
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  logic       fifo_full_i,
  output logic [1:0] grant_o,
  output logic       accept0_o,
  output logic       accept1_o
);

  localparam int unsigned BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);

  arb_state_e    state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          last_q, last_d;   // 0 = producer 0 held the last grant, 1 = producer 1

  logic       own_v, oth_v, own_id, acc;
  arb_state_e oth_st;

  always_comb begin
    grant_o   = grant_of(state_q);
    accept0_o = (state_q == ST_G0) & valid0_i & ~fifo_full_i;
    accept1_o = (state_q == ST_G1) & valid1_i & ~fifo_full_i;

    own_id = (state_q == ST_G1);
    own_v  = own_id ? valid1_i : valid0_i;
    oth_v  = own_id ? valid0_i : valid1_i;
    oth_st = own_id ? ST_G0 : ST_G1;
    acc    = accept0_o | accept1_o;

    state_d = state_q;
    burst_d = burst_q;
    last_d  = last_q;

    unique case (state_q)
      ST_IDLE: begin
        burst_d = '0;
        if (valid0_i && valid1_i) state_d = last_q ? ST_G0 : ST_G1;
        else if (valid0_i)        state_d = ST_G0;
        else if (valid1_i)        state_d = ST_G1;
      end
      ST_G0, ST_G1: begin
        // Valid drop beats burst completion; a full FIFO blocks acc so burst_q holds.
        if (!own_v) begin
          last_d  = own_id;
          burst_d = '0;
          state_d = oth_v ? oth_st : ST_IDLE;
        end else if (acc) begin
          if (burst_q == BURST_LAST) begin
            last_d  = own_id;
            burst_d = '0;
            if (oth_v) state_d = oth_st;
          end else begin
            burst_d = burst_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      burst_q <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: rtl/fifo_arb_amisha.sv
// Two-producer write arbiter and valid/ready read sequencer around an external FIFO.
module fifo_arb_amisha
  import fifo_arb_pkg_amisha::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned BURST_LEN = DEF_BURST_LEN,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic              clk_amisha,
  input  logic              reset_amisha,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              fifo_wr,
  output logic [DATA_W-1:0] fifo_w_data,
  output logic              fifo_rd,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_r_data,
  output logic [1:0]        grant,
  output logic [CNT_W-1:0]  acc0_cnt,
  output logic [CNT_W-1:0]  acc1_cnt
);

  logic             accept0, accept1;
  logic [CNT_W-1:0] acc0_q, acc0_d, acc1_q, acc1_d;

  rr_burst_fsm_amisha #(.BURST_LEN(BURST_LEN)) u_fsm (
    .clk_i       (clk_amisha),
    .rst_ni      (reset_amisha),
    .valid0_i    (req0_valid),
    .valid1_i    (req1_valid),
    .fifo_full_i (fifo_full),
    .grant_o     (grant),
    .accept0_o   (accept0),
    .accept1_o   (accept1)
  );

  always_comb begin
    req0_ready  = grant[0] & ~fifo_full;
    req1_ready  = grant[1] & ~fifo_full;
    fifo_wr     = accept0 | accept1;
    fifo_w_data = grant[1] ? req1_data : req0_data;

    out_valid = ~fifo_empty;
    out_data  = fifo_r_data;
    fifo_rd   = ~fifo_empty & out_ready;

    acc0_d = acc0_q + CNT_W'(accept0);
    acc1_d = acc1_q + CNT_W'(accept1);
  end

  always_ff @(posedge clk_amisha or negedge reset_amisha) begin
    if (!reset_amisha) begin
      acc0_q <= '0;
      acc1_q <= '0;
    end else begin
      acc0_q <= acc0_d;
      acc1_q <= acc1_d;
    end
  end

  assign acc0_cnt = acc0_q;
  assign acc1_cnt = acc1_q;

endmodule

// File: tb/tb_fifo_arb_amisha.sv
// Scoreboard bench for fifo_arb_amisha with a behavioural 16-deep FIFO stand-in.
module tb_fifo_arb_amisha;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n, fifo_rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_data, req1_data;
  logic       out_valid, out_ready, fifo_wr, fifo_rd, fifo_full, fifo_empty;
  logic [7:0] out_data, fifo_w_data, fifo_r_data;
  logic [1:0] grant;
  logic [3:0] acc0_cnt, acc1_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int wr_cycles = 0;

  logic [7:0] tx0[$], tx1[$], exp_rd[$];
  logic [8:0] exp_wr[$];

  fifo_arb_amisha #(.DATA_W(8), .BURST_LEN(4), .CNT_W(4)) dut (
    .clk_amisha(clk), .reset_amisha(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .fifo_wr(fifo_wr), .fifo_w_data(fifo_w_data), .fifo_rd(fifo_rd),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_r_data(fifo_r_data),
    .grant(grant), .acc0_cnt(acc0_cnt), .acc1_cnt(acc1_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: drops writes when full, ignores reads when empty.
  logic [7:0] mem[DEPTH];
  int         wp, rp, cnt;
  assign fifo_full   = (cnt == DEPTH);
  assign fifo_empty  = (cnt == 0);
  assign fifo_r_data = mem[rp];

  always @(posedge clk or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      wp <= 0; rp <= 0; cnt <= 0;
    end else begin
      if (fifo_wr && !fifo_full) begin
        mem[wp] <= fifo_w_data;
        wp <= (wp + 1) % DEPTH;
      end
      if (fifo_rd && !fifo_empty) rp <= (rp + 1) % DEPTH;
      cnt <= cnt + ((fifo_wr && !fifo_full) ? 1 : 0) - ((fifo_rd && !fifo_empty) ? 1 : 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tx_push(input bit p, input logic [7:0] d);
    if (p) tx1.push_back(d); else tx0.push_back(d);
  endtask

  task automatic exp_push(input bit p, input logic [7:0] d);
    exp_wr.push_back({p, d});
  endtask

  task automatic send(input bit p, input logic [7:0] d);
    tx_push(p, d);
    exp_push(p, d);
  endtask

  // Producers: hold word stable until accepted, then present the next one.
  always @(posedge clk) begin
    if (req0_valid && req0_ready) void'(tx0.pop_front());
    if (req1_valid && req1_ready) void'(tx1.pop_front());
    #1;
    req0_valid = (tx0.size() != 0);
    req0_data  = (tx0.size() != 0) ? tx0[0] : 8'h00;
    req1_valid = (tx1.size() != 0);
    req1_data  = (tx1.size() != 0) ? tx1[0] : 8'h00;
  end

  // Scoreboard: sample 1 ns before the active edge, when all inputs are settled.
  always @(negedge clk) begin
    logic [8:0] e;
    logic [7:0] r;
    #4;
    if (fifo_wr) begin
      wr_cycles++;
      if (exp_wr.size() == 0) chk("wr_unexpected", 32'(fifo_wr), 0);
      else begin
        e = exp_wr.pop_front();
        chk("wr_word", 32'({grant[1], fifo_w_data}), 32'(e));
        exp_rd.push_back(e[7:0]);
      end
    end
    if (fifo_rd) begin
      if (exp_rd.size() == 0) chk("rd_unexpected", 32'(fifo_rd), 0);
      else begin
        r = exp_rd.pop_front();
        chk("rd_word", 32'(out_data), 32'(r));
      end
    end
  end

  task automatic wait_idle(input bit need_empty);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = (tx0.size() == 0) && (tx1.size() == 0) && (grant == 2'b00) &&
             (!need_empty || fifo_empty);
    end
    chk("wait_timeout", 32'(done), 1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    wait_idle(1'b1);
    out_ready = 1'b0;
    chk("sb_rd_left", 32'(exp_rd.size()), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_ready", 32'({req1_ready, req0_ready}), 0);
    chk("rst_wr", 32'(fifo_wr), 0);
    chk("rst_cnt", 32'({acc1_cnt, acc0_cnt}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst_n = 1'b0; fifo_rst_n = 1'b0; out_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
    #12 fifo_rst_n = 1'b1;

    // 1: single producer, three words
    do_reset();
    @(negedge clk);
    wr_cycles = 0;
    send(0, 8'h11); send(0, 8'h22); send(0, 8'h33);
    @(negedge clk);
    chk("t1_idle_grant", 32'(grant), 0);
    @(negedge clk);
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_ready0", 32'(req0_ready), 1);
    repeat (4) @(negedge clk);
    chk("t1_back_idle", 32'(grant), 0);
    chk("t1_wr_cycles", 32'(wr_cycles), 3);
    chk("t1_acc0", 32'(acc0_cnt), 3);
    drain();

    // 2: both producers, bursts of four alternate
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 8; i++) tx_push(0, 8'(i));
    for (int i = 0; i < 4; i++) tx_push(1, 8'(128 + i));
    for (int i = 0; i < 4; i++) exp_push(0, 8'(i));
    for (int i = 0; i < 4; i++) exp_push(1, 8'(128 + i));
    for (int i = 4; i < 8; i++) exp_push(0, 8'(i));
    wait_idle(1'b0);
    chk("t2_acc0", 32'(acc0_cnt), 8);
    chk("t2_acc1", 32'(acc1_cnt), 4);
    chk("t2_sb_wr_left", 32'(exp_wr.size()), 0);
    drain();

    // 3: fill to full under G1, then one pop
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 20; i++) send(1, 8'(64 + i));
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = fifo_full;
    end
    chk("t3_full_reached", 32'(ok), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_ready1_full", 32'(req1_ready), 0);
      chk("t3_wr_full", 32'(fifo_wr), 0);
      chk("t3_grant_full", 32'(grant), 32'h2);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("t3_resume_wr", 32'(fifo_wr), 1);
    chk("t3_resume_ready", 32'(req1_ready), 1);
    drain();
    chk("t3_acc1_wrapped", 32'(acc1_cnt), 4);

    // 4: read drain of two words
    do_reset();
    @(negedge clk);
    send(0, 8'hA5); send(0, 8'h5A);
    wait_idle(1'b0);
    out_ready = 1'b1;
    #1;
    chk("t4_valid0", 32'(out_valid), 1);
    chk("t4_data0", 32'(out_data), 32'hA5);
    chk("t4_rd0", 32'(fifo_rd), 1);
    @(negedge clk);
    chk("t4_data1", 32'(out_data), 32'h5A);
    chk("t4_rd1", 32'(fifo_rd), 1);
    @(negedge clk);
    chk("t4_valid_empty", 32'(out_valid), 0);
    chk("t4_rd_empty", 32'(fifo_rd), 0);
    out_ready = 1'b0;

    // 5: async reset mid-burst, then tie goes to producer 0
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 6; i++) send(0, 8'(16 + i));
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = (grant == 2'b01);
    end
    chk("t5_grant_seen", 32'(ok), 1);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_ready0_drop", 32'(req0_ready), 0);
    chk("t5_wr_drop", 32'(fifo_wr), 0);
    chk("t5_grant_drop", 32'(grant), 0);
    chk("t5_cnt_clear", 32'({acc1_cnt, acc0_cnt}), 0);
    send(1, 8'hC1); send(1, 8'hC2);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_tie_p0", 32'(grant), 32'h1);
    wait_idle(1'b0);
    chk("t5_acc0", 32'(acc0_cnt), 4);
    chk("t5_acc1", 32'(acc1_cnt), 2);
    drain();

    // 6: 17 accepts on a 4-bit counter wrap to 1
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 17; i++) send(1, 8'(200 + i));
    drain();
    chk("t6_acc1_wrap", 32'(acc1_cnt), 1);
    chk("t6_acc0", 32'(acc0_cnt), 0);
    chk("sb_wr_left", 32'(exp_wr.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
